// File: rtl/risc16_operand_fetch.sv
// RiSC-16 decode/operand-fetch stage: register read, one-slot output to execute, RAW/WAW scoreboard.
// Define OF_WB_BYPASS_EN to forward writeback data and release busy registers in the writeback cycle.
module risc16_operand_fetch #(
    parameter int p_WORD_LEN      = 16,
    parameter int p_REG_ADDR_LEN  = 3,
    parameter int p_REG_FILE_SIZE = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_valid,
    input  logic [p_WORD_LEN-1:0]     i_instr,
    input  logic [p_WORD_LEN-1:0]     i_pc,
    output logic                      i_ready,
    output logic [p_REG_ADDR_LEN-1:0] rf_src1,
    output logic [p_REG_ADDR_LEN-1:0] rf_src2,
    input  logic [p_WORD_LEN-1:0]     rf_out1,
    input  logic [p_WORD_LEN-1:0]     rf_out2,
    input  logic                      wb_en,
    input  logic [p_REG_ADDR_LEN-1:0] wb_tgt,
    input  logic [p_WORD_LEN-1:0]     wb_data,
    input  logic                      flush,
    output logic                      ex_valid,
    input  logic                      ex_ready,
    output logic [2:0]                ex_op,
    output logic [p_REG_ADDR_LEN-1:0] ex_tgt,
    output logic [p_WORD_LEN-1:0]     ex_opa,
    output logic [p_WORD_LEN-1:0]     ex_opb,
    output logic [p_WORD_LEN-1:0]     ex_imm,
    output logic [p_WORD_LEN-1:0]     ex_pc
);

    typedef logic [p_REG_ADDR_LEN-1:0] addr_t;
    typedef logic [p_WORD_LEN-1:0]     word_t;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_ADDI = 3'b001;
    localparam logic [2:0] OP_NAND = 3'b010;
    localparam logic [2:0] OP_LUI  = 3'b011;
    localparam logic [2:0] OP_SW   = 3'b100;
    localparam logic [2:0] OP_LW   = 3'b101;
    localparam logic [2:0] OP_BEQ  = 3'b110;
    localparam logic [2:0] OP_JALR = 3'b111;

`ifdef OF_WB_BYPASS_EN
    localparam logic BYPASS = 1'b1;
`else
    localparam logic BYPASS = 1'b0;
`endif

    function automatic word_t sext7(input logic signed [6:0] v);
        return {{(p_WORD_LEN-7){v[6]}}, v};
    endfunction

    // A register stalls while busy, unless the bypass lets this cycle's writeback release it.
    function automatic logic reg_stall(input addr_t a, input logic [p_REG_FILE_SIZE-1:0] bsy,
                                       input logic wen, input addr_t wtgt);
        logic released;
        released = BYPASS && wen && (wtgt == a);
        return (a != '0) && bsy[a] && !released;
    endfunction

    function automatic word_t pick_operand(input addr_t a, input word_t rf, input logic wen,
                                           input addr_t wtgt, input word_t wdata);
        if (a == '0)
            return '0;
        if (BYPASS && wen && (wtgt == a))
            return wdata;
        return rf;
    endfunction

    logic [2:0] op;
    addr_t      ra, rb, rc, tgt;
    word_t      imm, opa, opb;
    logic       hazard, accept;
    logic [p_REG_FILE_SIZE-1:0] busy, busy_nxt;

    assign op = i_instr[15:13];
    assign ra = i_instr[12:10];
    assign rb = i_instr[9:7];
    assign rc = i_instr[2:0];

    always_comb begin
        rf_src1 = '0;
        rf_src2 = '0;
        tgt     = ra;
        imm     = '0;
        case (op)
            OP_ADD, OP_NAND: begin
                rf_src1 = rb;
                rf_src2 = rc;
            end
            OP_ADDI, OP_LW: begin
                rf_src1 = rb;
                imm     = sext7(i_instr[6:0]);
            end
            OP_JALR: rf_src1 = rb;
            OP_LUI:  imm = word_t'({i_instr[9:0], 6'b0});
            OP_SW: begin
                rf_src1 = rb;
                rf_src2 = ra;
                imm     = sext7(i_instr[6:0]);
                tgt     = '0;
            end
            OP_BEQ: begin
                rf_src1 = ra;
                rf_src2 = rb;
                imm     = sext7(i_instr[6:0]);
                tgt     = '0;
            end
            default: ;
        endcase
    end

    assign hazard = reg_stall(rf_src1, busy, wb_en, wb_tgt)
                  | reg_stall(rf_src2, busy, wb_en, wb_tgt)
                  | reg_stall(tgt, busy, wb_en, wb_tgt);
    assign i_ready = (!ex_valid || ex_ready) && !hazard && !flush;
    assign accept  = i_valid && i_ready;
    assign opa     = pick_operand(rf_src1, rf_out1, wb_en, wb_tgt, wb_data);
    assign opb     = pick_operand(rf_src2, rf_out2, wb_en, wb_tgt, wb_data);

    // Clears first so that a same-cycle set on the same register wins.
    always_comb begin
        busy_nxt = busy;
        if (wb_en && wb_tgt != '0)
            busy_nxt[wb_tgt] = 1'b0;
        if (flush && ex_valid && ex_tgt != '0)
            busy_nxt[ex_tgt] = 1'b0;
        if (accept && tgt != '0)
            busy_nxt[tgt] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    // Stage boundary: decoded operands into the execute slot
    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= '0;
            ex_valid <= 1'b0;
            ex_op    <= '0;
            ex_tgt   <= '0;
            ex_opa   <= '0;
            ex_opb   <= '0;
            ex_imm   <= '0;
            ex_pc    <= '0;
        end else begin
            busy <= busy_nxt;
            if (flush) begin
                ex_valid <= 1'b0;
            end else if (accept) begin
                ex_valid <= 1'b1;
                ex_op    <= op;
                ex_tgt   <= tgt;
                ex_opa   <= opa;
                ex_opb   <= opb;
                ex_imm   <= imm;
                ex_pc    <= i_pc;
            end else if (ex_ready) begin
                ex_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_risc16_operand_fetch.sv
// Bench for risc16_operand_fetch: directed test-plan sequence, then randomized traffic vs a behavioural model.
module tb_risc16_operand_fetch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, i_valid, wb_en, flush, ex_ready;
    logic [15:0] i_instr, i_pc, wb_data;
    logic [2:0]  wb_tgt;
    logic        i_ready, ex_valid;
    logic [2:0]  rf_src1, rf_src2, ex_op, ex_tgt;
    logic [15:0] rf_out1, rf_out2, ex_opa, ex_opb, ex_imm, ex_pc;

    logic [15:0] regs [8];
    assign rf_out1 = regs[rf_src1];
    assign rf_out2 = regs[rf_src2];

    risc16_operand_fetch dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_instr(i_instr), .i_pc(i_pc),
        .i_ready(i_ready), .rf_src1(rf_src1), .rf_src2(rf_src2),
        .rf_out1(rf_out1), .rf_out2(rf_out2), .wb_en(wb_en), .wb_tgt(wb_tgt),
        .wb_data(wb_data), .flush(flush), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_op(ex_op), .ex_tgt(ex_tgt), .ex_opa(ex_opa), .ex_opb(ex_opb),
        .ex_imm(ex_imm), .ex_pc(ex_pc)
    );

`ifdef OF_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    // Reference state: busy set, output slot, register file contents
    logic [7:0]  m_busy;
    logic        m_v;
    logic [2:0]  m_op, m_tgt;
    logic [15:0] m_opa, m_opb, m_imm, m_pc;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void decode(input logic [15:0] ins, output logic [2:0] s1,
                                   output logic [2:0] s2, output logic [2:0] t,
                                   output logic [15:0] imm);
        int o;
        o  = int'(ins[15:13]);
        s1 = (o == 3) ? 3'd0 : (o == 6) ? ins[12:10] : ins[9:7];
        s2 = (o == 0 || o == 2) ? ins[2:0] : (o == 4) ? ins[12:10] : (o == 6) ? ins[9:7] : 3'd0;
        t  = (o == 4 || o == 6) ? 3'd0 : ins[12:10];
        if (o == 1 || o == 4 || o == 5 || o == 6)
            imm = ins[6] ? (16'hFF80 | {9'd0, ins[6:0]}) : {9'd0, ins[6:0]};
        else if (o == 3)
            imm = 16'({6'd0, ins[9:0]} * 64);
        else
            imm = 16'd0;
    endfunction

    function automatic bit m_stall(input logic [2:0] r);
        if (r == 3'd0 || !m_busy[r]) return 1'b0;
        if (BYP && wb_en && wb_tgt == r) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [15:0] m_operand(input logic [2:0] r);
        if (r == 3'd0) return 16'd0;
        if (BYP && wb_en && wb_tgt == r) return wb_data;
        return regs[r];
    endfunction

    // One clock: drive at negedge, compare before the edge, advance the model after it.
    task automatic cyc(input logic r, input logic v, input logic [15:0] ins, input logic er,
                       input logic fl, input logic we, input logic [2:0] wt, input logic [15:0] wd,
                       output logic ir, output logic [2:0] s1o, output logic [2:0] s2o);
        logic [2:0]  s1, s2, t;
        logic [15:0] imm, a, b;
        logic        exp_rdy, acc;
        logic [7:0]  nb;
        @(negedge clk);
        rst = r; i_valid = v; i_instr = ins; i_pc = 16'($urandom);
        ex_ready = er; flush = fl; wb_en = we; wb_tgt = wt; wb_data = wd;
        #1;
        ir = i_ready; s1o = rf_src1; s2o = rf_src2;
        decode(ins, s1, s2, t, imm);
        exp_rdy = (!m_v || er) && !m_stall(s1) && !m_stall(s2) && !m_stall(t) && !fl;
        check("rf_src1", {13'd0, rf_src1}, {13'd0, s1});
        check("rf_src2", {13'd0, rf_src2}, {13'd0, s2});
        check("i_ready", {15'd0, i_ready}, {15'd0, exp_rdy});
        check("ex_valid", {15'd0, ex_valid}, {15'd0, m_v});
        if (m_v) begin
            check("ex_op", {13'd0, ex_op}, {13'd0, m_op});
            check("ex_tgt", {13'd0, ex_tgt}, {13'd0, m_tgt});
            check("ex_opa", ex_opa, m_opa);
            check("ex_opb", ex_opb, m_opb);
            check("ex_imm", ex_imm, m_imm);
            check("ex_pc", ex_pc, m_pc);
        end
        acc = v && exp_rdy;
        a = m_operand(s1);
        b = m_operand(s2);
        nb = m_busy;
        if (we && wt != 0) nb[wt] = 1'b0;
        if (fl && m_v && m_tgt != 0) nb[m_tgt] = 1'b0;
        if (acc && t != 0) nb[t] = 1'b1;
        @(posedge clk);
        #1;
        if (we && wt != 0) regs[wt] = wd;
        if (r) begin
            m_busy = 8'd0; m_v = 1'b0; m_op = 3'd0; m_tgt = 3'd0;
            m_opa = 16'd0; m_opb = 16'd0; m_imm = 16'd0; m_pc = 16'd0;
        end else begin
            m_busy = nb;
            if (fl) m_v = 1'b0;
            else if (acc) begin
                m_v = 1'b1; m_op = ins[15:13]; m_tgt = t;
                m_opa = a; m_opb = b; m_imm = imm; m_pc = i_pc;
            end else if (er) m_v = 1'b0;
        end
    endtask

    initial begin
        logic ir;
        logic [2:0] s1, s2, wt;
        for (int i = 0; i < 8; i++) regs[i] = 16'(16'h1111 * i);
        rst = 1'b1; i_valid = 1'b0; i_instr = 16'd0; i_pc = 16'd0; ex_ready = 1'b1;
        flush = 1'b0; wb_en = 1'b0; wb_tgt = 3'd0; wb_data = 16'd0;
        m_busy = 8'd0; m_v = 1'b0; m_op = 3'd0; m_tgt = 3'd0;
        m_opa = 16'd0; m_opb = 16'd0; m_imm = 16'd0; m_pc = 16'd0;
        repeat (2) @(posedge clk);

        cyc(1, 0, 16'h0000, 1, 0, 0, 3'd0, 16'd0, ir, s1, s2);
        check("rst_valid", {15'd0, ex_valid}, 16'd0);
        check("rst_opa", ex_opa, 16'd0);
        check("rst_imm", ex_imm, 16'd0);

        cyc(0, 1, 16'h2405, 1, 0, 0, 3'd0, 16'd0, ir, s1, s2);
        check("addi_ready", {15'd0, ir}, 16'd1);
        check("addi_valid", {15'd0, ex_valid}, 16'd1);
        check("addi_op", {13'd0, ex_op}, 16'd1);
        check("addi_tgt", {13'd0, ex_tgt}, 16'd1);
        check("addi_imm", ex_imm, 16'h0005);

        cyc(0, 1, 16'h287F, 1, 0, 0, 3'd0, 16'd0, ir, s1, s2);
        check("addi_neg_imm", ex_imm, 16'hFFFF);

        cyc(0, 1, 16'h6FFF, 1, 0, 0, 3'd0, 16'd0, ir, s1, s2);
        check("lui_src1", {13'd0, s1}, 16'd0);
        check("lui_src2", {13'd0, s2}, 16'd0);
        check("lui_imm", ex_imm, 16'hFFC0);

        cyc(0, 0, 16'h0000, 1, 0, 1, 3'd2, 16'h0022, ir, s1, s2);
        cyc(0, 0, 16'h0000, 1, 0, 1, 3'd3, 16'h0033, ir, s1, s2);

        repeat (2) begin
            cyc(0, 1, 16'h0881, 1, 0, 0, 3'd0, 16'd0, ir, s1, s2);
            check("raw_stall", {15'd0, ir}, 16'd0);
        end
        cyc(0, 1, 16'h0881, 1, 0, 1, 3'd1, 16'h0005, ir, s1, s2);
`ifdef OF_WB_BYPASS_EN
        check("bypass_accept", {15'd0, ir}, 16'd1);
`else
        check("wb_cycle_stall", {15'd0, ir}, 16'd0);
        cyc(0, 1, 16'h0881, 1, 0, 0, 3'd0, 16'd0, ir, s1, s2);
        check("after_wb_accept", {15'd0, ir}, 16'd1);
`endif
        check("raw_opa", ex_opa, 16'h0005);
        check("raw_opb", ex_opb, 16'h0005);

        repeat (3) begin
            cyc(0, 1, 16'h3407, 0, 0, 0, 3'd0, 16'd0, ir, s1, s2);
            check("hold_ready", {15'd0, ir}, 16'd0);
            check("hold_tgt", {13'd0, ex_tgt}, 16'd2);
            check("hold_opa", ex_opa, 16'h0005);
        end
        cyc(0, 1, 16'h3407, 1, 0, 0, 3'd0, 16'd0, ir, s1, s2);
        check("release_ready", {15'd0, ir}, 16'd1);
        check("release_tgt", {13'd0, ex_tgt}, 16'd5);

        cyc(0, 1, 16'hB000, 1, 0, 0, 3'd0, 16'd0, ir, s1, s2);
        check("lw_tgt", {13'd0, ex_tgt}, 16'd4);
        cyc(0, 1, 16'h3801, 1, 1, 0, 3'd0, 16'd0, ir, s1, s2);
        check("flush_no_accept", {15'd0, ir}, 16'd0);
        check("flush_valid", {15'd0, ex_valid}, 16'd0);
        cyc(0, 1, 16'h3001, 1, 0, 0, 3'd0, 16'd0, ir, s1, s2);
        check("flush_busy_clear", {15'd0, ir}, 16'd1);

        cyc(1, 1, 16'h3001, 0, 0, 0, 3'd0, 16'd0, ir, s1, s2);
        check("midrst_valid", {15'd0, ex_valid}, 16'd0);
        check("midrst_tgt", {13'd0, ex_tgt}, 16'd0);
        check("midrst_pc", ex_pc, 16'd0);
        check("midrst_opb", ex_opb, 16'd0);
        cyc(0, 1, 16'h1504, 1, 0, 0, 3'd0, 16'd0, ir, s1, s2);
        check("midrst_busy_clear", {15'd0, ir}, 16'd1);

        for (int n = 0; n < 3000; n++) begin
            wt = 3'($urandom_range(0, 7));
            for (int k = 0; k < 3; k++)
                if (!m_busy[wt]) wt = 3'($urandom_range(0, 7));
            cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 7), 16'($urandom),
                ($urandom_range(0, 9) < 7), ($urandom_range(0, 24) == 0),
                ($urandom_range(0, 9) < 4), wt, 16'($urandom), ir, s1, s2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
